// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared state encoding and default timing constants for the lock-in ADC sequencer
package lockin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Defaults assume a 36 MHz system clock
    localparam int NBITS_DEF    = 16;
    localparam int DIV_DEF      = 2;    // 9 MHz SCLK
    localparam int CONV_CYC_DEF = 72;   // 2 us conversion
    localparam int RATE_DIV_DEF = 360;  // 100 kSa/s

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_timer.sv
// rtl/sample_timer.sv - sample-rate counter with enable gating; optional REFIN phase restart under REFSYNC_EN
module sample_timer
    import lockin_pkg::*;
#(
    parameter int RATE_DIV = RATE_DIV_DEF
) (
    input  logic i_clk36,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_refin,
    output logic o_tick
);

    localparam int CW = cnt_w(RATE_DIV);
    localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_restart;

`ifdef REFSYNC_EN
    logic r_ref_s1;
    logic r_ref_s2;
    logic r_ref_d;

    // Two-flop synchronizer for the asynchronous reference plus a delay stage for edge detection
    always_ff @(posedge i_clk36) begin
        if (i_rst) begin
            r_ref_s1 <= 1'b0;
            r_ref_s2 <= 1'b0;
            r_ref_d  <= 1'b0;
        end else begin
            r_ref_s1 <= i_refin;
            r_ref_s2 <= r_ref_s1;
            r_ref_d  <= r_ref_s2;
        end
    end

    assign w_restart = r_ref_s2 & ~r_ref_d;
`else
    // Reference is ignored in this build; the AND keeps the pin formally consumed
    assign w_restart = i_refin & 1'b0;
`endif

    // A reference edge restarts the period, so it also swallows a coincident tick
    assign o_tick = i_en && !w_restart && (r_count == LAST);

    // Free-running period counter, held at zero while disabled
    always_ff @(posedge i_clk36) begin
        if (i_rst || !i_en || w_restart || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - periodic CONVST, serial readout and config shift for the front-end ADC (REFSYNC_EN optional)
module adc_sample_sequencer
    import lockin_pkg::*;
#(
    parameter int NBITS    = NBITS_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int CONV_CYC = CONV_CYC_DEF,
    parameter int RATE_DIV = RATE_DIV_DEF
) (
    input  logic             i_clk36,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [NBITS-1:0] i_cfg,
    input  logic             i_refin,
    output logic             o_convst,
    output logic             o_sclk,
    output logic             o_sdi,
    input  logic             i_sdo,
    output logic [NBITS-1:0] o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_ovr
);

    localparam int PW  = cnt_w(2 * DIV);
    localparam int BW  = cnt_w(NBITS);
    localparam int CCW = cnt_w(CONV_CYC);

    localparam logic [PW-1:0]  PH_RISE = PW'(DIV);
    localparam logic [PW-1:0]  PH_LAST = PW'(2 * DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(NBITS - 1);
    localparam logic [CCW-1:0] CONV_LAST = CCW'(CONV_CYC - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CCW-1:0]   r_conv_cnt;
    logic [PW-1:0]    r_phase;
    logic [BW-1:0]    r_bit;
    logic [NBITS-1:0] r_tx;
    logic [NBITS-1:0] r_rx;
    logic [NBITS-1:0] r_data;
    logic             r_valid;
    logic             r_ovr;
    logic             w_tick;
    logic             w_conv_last;
    logic             w_bit_end;
    logic             w_sclk_rise;
    logic             w_last_bit;

    sample_timer #(
        .RATE_DIV (RATE_DIV)
    ) u_timer (
        .i_clk36 (i_clk36),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_refin (i_refin),
        .o_tick  (w_tick)
    );

    assign w_conv_last = (r_conv_cnt == CONV_LAST);
    assign w_bit_end   = (r_phase == PH_LAST);
    assign w_sclk_rise = (r_phase == PH_RISE);
    assign w_last_bit  = (r_bit == BIT_LAST);

    // State register
    always_ff @(posedge i_clk36) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pin decode; the serial clock is low for the first DIV cycles of each bit
    always_comb begin
        w_state_nxt = r_state;
        o_convst    = 1'b0;
        o_sclk      = 1'b0;
        o_sdi       = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_tick) begin
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                o_convst = 1'b1;
                if (w_conv_last) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_sclk = (r_phase >= PH_RISE);
                o_sdi  = r_tx[NBITS-1];
                if (w_bit_end && w_last_bit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counters and shift registers; TX advances at bit end so SDI changes only at the start of a low phase
    always_ff @(posedge i_clk36) begin
        if (i_rst) begin
            r_conv_cnt <= '0;
            r_phase    <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_conv_cnt <= '0;
                    r_phase    <= '0;
                    r_bit      <= '0;
                    if (w_tick) begin
                        r_tx <= i_cfg;
                    end
                end
                ST_CONV: begin
                    r_conv_cnt <= r_conv_cnt + 1'b1;
                end
                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx <= {r_rx[NBITS-2:0], i_sdo};
                    end
                    if (w_bit_end) begin
                        r_phase <= '0;
                        r_bit   <= r_bit + 1'b1;
                        r_tx    <= {r_tx[NBITS-2:0], 1'b0};
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_phase <= '0;
                end
            endcase
        end
    end

    // Result hand-off and sticky overrun; a tick in any non-idle state, DONE included, is dropped
    always_ff @(posedge i_clk36) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_data <= r_rx;
            end
            if (w_tick && (r_state != ST_IDLE)) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_ovr   = r_ovr;

endmodule
